// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC engine: mode encodings, the
// micro-rotation angle table and the output gain correction.
package cordic_pkg;

  localparam logic CORDIC_ROT = 1'b0;
  localparam logic CORDIC_VEC = 1'b1;

  // atan(2^-i) on a 2^32 full-circle scale; rescaled to ZW bits by atan_lut
  function automatic logic [63:0] atan32(input int i);
    case (i)
      0:  atan32 = 64'd536870912;
      1:  atan32 = 64'd316933406;
      2:  atan32 = 64'd167458907;
      3:  atan32 = 64'd85004756;
      4:  atan32 = 64'd42667331;
      5:  atan32 = 64'd21354465;
      6:  atan32 = 64'd10679838;
      7:  atan32 = 64'd5340245;
      8:  atan32 = 64'd2670163;
      9:  atan32 = 64'd1335087;
      10: atan32 = 64'd667544;
      11: atan32 = 64'd333772;
      12: atan32 = 64'd166886;
      13: atan32 = 64'd83443;
      14: atan32 = 64'd41722;
      15: atan32 = 64'd20861;
      16: atan32 = 64'd10430;
      17: atan32 = 64'd5215;
      18: atan32 = 64'd2608;
      19: atan32 = 64'd1304;
      20: atan32 = 64'd652;
      21: atan32 = 64'd326;
      22: atan32 = 64'd163;
      23: atan32 = 64'd81;
      24: atan32 = 64'd41;
      25: atan32 = 64'd20;
      26: atan32 = 64'd10;
      27: atan32 = 64'd5;
      28: atan32 = 64'd3;
      29: atan32 = 64'd1;
      30: atan32 = 64'd1;
      default: atan32 = 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] atan_lut(input int i, input int zw);
    logic [63:0] v;
    v = atan32(i);
    if (zw >= 32) atan_lut = v << (zw - 32);
    else          atan_lut = (v + (64'd1 << (31 - zw))) >> (32 - zw);
  endfunction

  // round(0.6072529 * 2^w), from a 2^32-scaled constant
  function automatic logic [63:0] gain_kc(input int w);
    logic [63:0] k;
    k = 64'd2608131346;
    if (w >= 32) gain_kc = k << (w - 32);
    else         gain_kc = (k + (64'd1 << (31 - w))) >> (32 - w);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; every register holds while en is low.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int             IW    = 18,
  parameter int             AW    = 17,
  parameter int             SHIFT = 0,
  parameter logic [AW-1:0]  ATAN  = '0,
  parameter int             TAG_W = 4
) (
  input  logic                    CLK_50M,
  input  logic                    RST_N,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [IW-1:0]    in_x,
  input  logic signed [IW-1:0]    in_y,
  input  logic signed [AW-1:0]    in_z,
  output logic                    out_valid,
  output logic                    out_mode,
  output logic [TAG_W-1:0]        out_tag,
  output logic signed [IW-1:0]    out_x,
  output logic signed [IW-1:0]    out_y,
  output logic signed [AW-1:0]    out_z
);

  logic                 dir;
  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  always_comb begin
    dir  = (in_mode == CORDIC_VEC) ? in_y[IW-1] : !in_z[AW-1];
    x_sh = in_x >>> SHIFT;
    y_sh = in_y >>> SHIFT;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      out_x     <= dir ? in_x - y_sh : in_x + y_sh;
      out_y     <= dir ? in_y + x_sh : in_y - x_sh;
      out_z     <= dir ? in_z - $signed(ATAN) : in_z + $signed(ATAN);
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined rotation/vectoring CORDIC: quadrant pre-fold, ITER
// micro-rotations, gain correction with saturation, one global stall.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int W     = 16,
  parameter int ZW    = 16,
  parameter int ITER  = 14,
  parameter int TAG_W = 4
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [W-1:0]      in_x,
  input  logic [W-1:0]      in_y,
  input  logic [ZW-1:0]     in_z,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_x,
  output logic [W-1:0]      out_y,
  output logic [ZW-1:0]     out_z,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_mode
);

  localparam int IW = W + 2;
  localparam int AW = ZW + 1;
  localparam int PW = IW + W + 1;
  localparam logic [W-1:0]          KC     = W'(gain_kc(W));
  localparam logic signed [PW-1:0]  SAT_HI = (PW'(1) <<< (W - 1)) - PW'(1);
  localparam logic signed [PW-1:0]  SAT_LO = -(PW'(1) <<< (W - 1));

  logic                 en;
  logic signed [IW-1:0] ext_x, ext_y, pre_x, pre_y;
  logic signed [AW-1:0] pre_z;
  logic                 s0_valid, s0_mode;
  logic [TAG_W-1:0]     s0_tag;
  logic signed [IW-1:0] s0_x, s0_y;
  logic signed [AW-1:0] s0_z;

  logic                 st_valid [ITER+1];
  logic                 st_mode  [ITER+1];
  logic [TAG_W-1:0]     st_tag   [ITER+1];
  logic signed [IW-1:0] st_x     [ITER+1];
  logic signed [IW-1:0] st_y     [ITER+1];
  logic signed [AW-1:0] st_z     [ITER+1];
  logic                 unused_z_msb;

  assign en           = !(out_valid && !out_ready);
  assign in_ready     = en;
  assign unused_z_msb = st_z[ITER][ZW];

  // Rotation folds the vector by the top two angle bits so the residual
  // stays in [0, 90 deg); vectoring mirrors the left half-plane.
  always_comb begin
    ext_x = {{2{in_x[W-1]}}, in_x};
    ext_y = {{2{in_y[W-1]}}, in_y};
    pre_x = ext_x;
    pre_y = ext_y;
    pre_z = '0;
    if (in_mode == CORDIC_VEC) begin
      if (ext_x[IW-1]) begin
        pre_x = -ext_x;
        pre_y = -ext_y;
        pre_z = {2'b01, {(ZW-1){1'b0}}};
      end
    end else begin
      pre_z = {3'b000, in_z[ZW-3:0]};
      case (in_z[ZW-1:ZW-2])
        2'd1:    begin pre_x = -ext_y; pre_y =  ext_x; end
        2'd2:    begin pre_x = -ext_x; pre_y = -ext_y; end
        2'd3:    begin pre_x =  ext_y; pre_y = -ext_x; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      s0_valid <= 1'b0;
      s0_mode  <= 1'b0;
      s0_tag   <= '0;
      s0_x     <= '0;
      s0_y     <= '0;
      s0_z     <= '0;
    end else if (en) begin
      s0_valid <= in_valid;
      s0_mode  <= in_mode;
      s0_tag   <= in_tag;
      s0_x     <= pre_x;
      s0_y     <= pre_y;
      s0_z     <= pre_z;
    end
  end

  assign st_valid[0] = s0_valid;
  assign st_mode[0]  = s0_mode;
  assign st_tag[0]   = s0_tag;
  assign st_x[0]     = s0_x;
  assign st_y[0]     = s0_y;
  assign st_z[0]     = s0_z;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(
      .IW(IW), .AW(AW), .SHIFT(i), .ATAN(AW'(atan_lut(i, ZW))), .TAG_W(TAG_W)
    ) u_stage (
      .CLK_50M  (CLK_50M),
      .RST_N    (RST_N),
      .en       (en),
      .in_valid (st_valid[i]),
      .in_mode  (st_mode[i]),
      .in_tag   (st_tag[i]),
      .in_x     (st_x[i]),
      .in_y     (st_y[i]),
      .in_z     (st_z[i]),
      .out_valid(st_valid[i+1]),
      .out_mode (st_mode[i+1]),
      .out_tag  (st_tag[i+1]),
      .out_x    (st_x[i+1]),
      .out_y    (st_y[i+1]),
      .out_z    (st_z[i+1])
    );
  end

  function automatic logic [W-1:0] scale_sat(input logic signed [IW-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * PW'($signed({1'b0, KC}));
    p = (p + (PW'(1) <<< (W - 1))) >>> W;
    if (p > SAT_HI)      scale_sat = SAT_HI[W-1:0];
    else if (p < SAT_LO) scale_sat = SAT_LO[W-1:0];
    else                 scale_sat = p[W-1:0];
  endfunction

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= st_valid[ITER];
      out_mode  <= st_mode[ITER];
      out_tag   <= st_tag[ITER];
      out_x     <= scale_sat(st_x[ITER]);
      out_y     <= scale_sat(st_y[ITER]);
      out_z     <= st_z[ITER][ZW-1:0];
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed rotation/vectoring/saturation cases, random
// streams against a trigonometric reference, backpressure and reset mid-stream.
module tb_cordic_pipe;

  localparam int  W = 16, ZW = 16, ITER = 14, TAG_W = 4;
  localparam int  XY_TOL = 6, ANG_TOL = 3, ANG_TOL_RND = 4;
  localparam real PI = 3.14159265358979323846;

  logic             CLK_50M = 1'b0;
  logic             RST_N;
  logic             in_valid, in_ready, in_mode;
  logic [W-1:0]     in_x, in_y;
  logic [ZW-1:0]    in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_mode;
  logic [W-1:0]     out_x, out_y;
  logic [ZW-1:0]    out_z;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit mode; int tag; int ex; int ey; int ez; } exp_t;
  exp_t sb[$];

  cordic_pipe #(.W(W), .ZW(ZW), .ITER(ITER), .TAG_W(TAG_W)) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_tag(out_tag), .out_mode(out_mode)
  );

  always #10 CLK_50M = ~CLK_50M;

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int adiff(input int a, input int b);
    int d;
    d = (a - b) & 32'hFFFF;
    if (d >= 32768) d = d - 65536;
    return absi(d);
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int sat16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  // Ideal result from trigonometry on the unquantised angle.
  function automatic void ref_model(input bit m, input int x, input int y, input int z,
                                    output int ex, output int ey, output int ez);
    real th, rx, ry;
    if (m == 1'b0) begin
      th = real'(z) * 2.0 * PI / 65536.0;
      rx = real'(x) * $cos(th) - real'(y) * $sin(th);
      ry = real'(x) * $sin(th) + real'(y) * $cos(th);
      ez = 0;
    end else begin
      rx = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      ry = 0.0;
      ez = rnd($atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI)) & 32'hFFFF;
    end
    ex = sat16(rnd(rx));
    ey = sat16(rnd(ry));
  endfunction

  function automatic void gen_sample(output bit m, output int x, output int y, output int z);
    m = 1'($urandom_range(0, 1));
    z = int'($urandom_range(0, 65535));
    if (m == 1'b0) begin
      x = int'($urandom_range(0, 24000)) - 12000;
      y = int'($urandom_range(0, 24000)) - 12000;
    end else begin
      do begin
        x = int'($urandom_range(0, 32000)) - 16000;
        y = int'($urandom_range(0, 32000)) - 16000;
      end while (x * x + y * y < 8192 * 8192);
    end
  endfunction

  task automatic send_and_wait(input bit m, input int x, input int y, input int z, input int tag,
                               output int ox, output int oy, output int oz, output int otag,
                               output int lat, output bit to);
    @(posedge CLK_50M); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_x      = W'(x);
    in_y      = W'(y);
    in_z      = ZW'(z);
    in_tag    = TAG_W'(tag);
    lat = 0;
    to  = 1'b1;
    for (int c = 0; c < 100 && to; c++) begin
      @(posedge CLK_50M); #1;
      lat++;
      in_valid = 1'b0;
      if (out_valid === 1'b1) to = 1'b0;
    end
    ox   = sx(out_x);
    oy   = sx(out_y);
    oz   = int'(out_z);
    otag = int'(out_tag);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #5;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++;
    if ({out_x, out_y, out_z, out_tag, out_mode} !== '0)
      begin n_fail++; $display("FAIL reset_data: got x=%h y=%h z=%h tag=%h expected all 0", out_x, out_y, out_z, out_tag); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (3) @(negedge CLK_50M);
    RST_N = 1'b1;
    @(posedge CLK_50M); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_rotation();
    int rz [3] = '{32'h2000, 32'h4000, 32'hC000};
    int rex[3] = '{11585, 0, 0};
    int rey[3] = '{11585, 16384, -16384};
    int ox, oy, oz, ot, lat;
    bit to;
    for (int k = 0; k < 3; k++) begin
      send_and_wait(1'b0, 16384, 0, rz[k], k, ox, oy, oz, ot, lat, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL rot_timeout[%0d]: no output within 100 cycles", k); end
      else begin
        if (k == 0) begin
          n_checks++;
          if (lat != 16) begin n_fail++; $display("FAIL rot_latency: got %0d expected 16", lat); end
        end
        n_checks++;
        if (absi(ox - rex[k]) > XY_TOL || absi(oy - rey[k]) > XY_TOL)
          begin n_fail++; $display("FAIL rot_xy[z=%h]: got (%0d,%0d) expected (%0d,%0d)", rz[k], ox, oy, rex[k], rey[k]); end
        n_checks++;
        if (ot != k) begin n_fail++; $display("FAIL rot_tag[%0d]: got %0d expected %0d", k, ot, k); end
      end
    end
  endtask

  task automatic test_vectoring();
    int vx [3] = '{16384, -16384, 0};
    int vy [3] = '{16384, 0, -16384};
    int vm [3] = '{23170, 16384, 16384};
    int vz [3] = '{32'h2000, 32'h8000, 32'hC000};
    int ox, oy, oz, ot, lat;
    bit to;
    for (int k = 0; k < 3; k++) begin
      send_and_wait(1'b1, vx[k], vy[k], 0, k + 4, ox, oy, oz, ot, lat, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL vec_timeout[%0d]: no output within 100 cycles", k); end
      else begin
        n_checks++;
        if (absi(ox - vm[k]) > XY_TOL)
          begin n_fail++; $display("FAIL vec_mag[%0d]: got %0d expected %0d", k, ox, vm[k]); end
        n_checks++;
        if (adiff(oz, vz[k]) > ANG_TOL)
          begin n_fail++; $display("FAIL vec_angle[%0d]: got %h expected %h", k, oz, vz[k]); end
      end
    end
  endtask

  task automatic test_saturation();
    int ox, oy, oz, ot, lat;
    bit to;
    send_and_wait(1'b1, 32767, 32767, 0, 9, ox, oy, oz, ot, lat, to);
    n_checks++;
    if (to || ox != 32767) begin n_fail++; $display("FAIL sat_vec_mag: got %0d expected 32767 (timeout=%0b)", ox, to); end
    send_and_wait(1'b0, -32768, 0, 32'h8000, 10, ox, oy, oz, ot, lat, to);
    n_checks++;
    if (to || ox != 32767) begin n_fail++; $display("FAIL sat_rot_x: got %0d expected 32767 (timeout=%0b)", ox, to); end
  endtask

  task automatic run_stream(input int count, input bit bp);
    int   sent = 0, recv = 0, cyc = 0;
    int   x, y, z;
    bit   m, prev_stall;
    logic [W-1:0]     px, py;
    logic [ZW-1:0]    pz;
    logic [TAG_W-1:0] pt;
    logic             pm;
    exp_t e;
    prev_stall = 1'b0;
    gen_sample(m, x, y, z);
    @(posedge CLK_50M); #1;
    while (recv < count && cyc < count * 8 + 200) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < count);
      in_mode   = m;
      in_x      = W'(x);
      in_y      = W'(y);
      in_z      = ZW'(z);
      in_tag    = TAG_W'(sent);
      @(negedge CLK_50M);
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready))
        begin n_fail++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready)); end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== px || out_y !== py || out_z !== pz || out_tag !== pt || out_mode !== pm)
          begin n_fail++; $display("FAIL stream_stable: got v=%b x=%h y=%h z=%h expected v=1 x=%h y=%h z=%h", out_valid, out_x, out_y, out_z, px, py, pz); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL stream_extra: got tag %0d expected no output", out_tag); end
        else begin
          e = sb.pop_front();
          recv++;
          if (int'(out_tag) != e.tag || out_mode !== e.mode)
            begin n_fail++; $display("FAIL stream_tag: got tag=%0d mode=%b expected tag=%0d mode=%b", out_tag, out_mode, e.tag, e.mode); end
          n_checks++;
          if (absi(sx(out_x) - e.ex) > XY_TOL || absi(sx(out_y) - e.ey) > XY_TOL)
            begin n_fail++; $display("FAIL stream_xy[tag %0d]: got (%0d,%0d) expected (%0d,%0d)", e.tag, sx(out_x), sx(out_y), e.ex, e.ey); end
          if (e.mode) begin
            n_checks++;
            if (adiff(int'(out_z), e.ez) > ANG_TOL_RND)
              begin n_fail++; $display("FAIL stream_angle[tag %0d]: got %h expected %h", e.tag, out_z, e.ez); end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      px = out_x; py = out_y; pz = out_z; pt = out_tag; pm = out_mode;
      if (in_valid && in_ready) begin
        e.mode = m;
        e.tag  = sent & ((1 << TAG_W) - 1);
        ref_model(m, x, y, z, e.ex, e.ey, e.ez);
        sb.push_back(e);
        sent++;
        gen_sample(m, x, y, z);
      end
      @(posedge CLK_50M); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != count || sb.size() != 0)
      begin n_fail++; $display("FAIL stream_count: got %0d received, %0d pending expected %0d, 0", recv, sb.size(), count); end
  endtask

  task automatic test_back_to_back();
    run_stream(100, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream(100, 1'b1);
  endtask

  task automatic test_reset_midstream();
    int  ox, oy, oz, ot, lat, stale;
    bit  to;
    @(posedge CLK_50M); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_x     = W'(1000 * (k + 1));
      in_y     = '0;
      in_z     = '0;
      in_tag   = TAG_W'(k);
      @(posedge CLK_50M); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge CLK_50M); #1; end
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || {out_x, out_y, out_z, out_tag, out_mode} !== '0)
      begin n_fail++; $display("FAIL midreset_outputs: got v=%b x=%h y=%h z=%h expected all 0", out_valid, out_x, out_y, out_z); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge CLK_50M);
    RST_N = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge CLK_50M); #1;
      if (out_valid === 1'b1) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL midreset_stale: got %0d outputs expected 0", stale); end
    send_and_wait(1'b0, 16384, 0, 32'h4000, 7, ox, oy, oz, ot, lat, to);
    n_checks++;
    if (to || lat != 16) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 16 (timeout=%0b)", lat, to); end
    n_checks++;
    if (absi(ox) > XY_TOL || absi(oy - 16384) > XY_TOL || ot != 7)
      begin n_fail++; $display("FAIL midreset_result: got (%0d,%0d) tag %0d expected (0,16384) tag 7", ox, oy, ot); end
  endtask

  initial begin
    RST_N     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_z      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    test_rotation();
    test_vectoring();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
